// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan display.
// Glyphs are active-low, segments a..g on bits [0]..[6].
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef logic [1:0] digit_idx_t;

    // Index 15 is leftmost in the concatenation, index 0 rightmost.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment glyph decoder.
// Latency: combinational. Backpressure: none.
import seg7_pkg::*;

module seg7_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver; SEG7_LEADING_ZERO_BLANK_EN adds leading-zero blanking.
// Latency: write reaches seg two edges after wr_en; an index change reaches the pins one edge later.
// Backpressure: none, every wr_en strobe is accepted and the last one wins.
import seg7_pkg::*;

module seg7_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [15:0]       wr_data,
    input  logic [DIGITS-1:0] wr_dp,
    input  logic [DIGITS-1:0] blank,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              scan_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]  cnt;
    digit_idx_t        idx;
    logic [15:0]       data_q;
    logic [DIGITS-1:0] dp_q;
    logic [DIGITS-1:0] dark;
    logic [3:0]        cur_nibble;
    logic [6:0]        cur_glyph;
    logic              cur_dark;

    assign scan_tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (scan_tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= 16'h0000;
            dp_q   <= '0;
        end else if (wr_en) begin
            data_q <= wr_data;
            dp_q   <= wr_dp;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit goes dark only if it and everything to its left is zero and its dp is off.
    logic [DIGITS-1:0] auto_blank;

    always_comb begin
        auto_blank    = '0;
        auto_blank[3] = (data_q[15:12] == 4'h0) && !dp_q[3];
        auto_blank[2] = (data_q[15:8]  == 8'h00) && !dp_q[2];
        auto_blank[1] = (data_q[15:4]  == 12'h000) && !dp_q[1];
    end

    assign dark = blank | auto_blank;
`else
    assign dark = blank;
`endif

    assign cur_nibble = data_q[{idx, 2'b00} +: 4];
    assign cur_dark   = dark[idx];

    seg7_hex_decode u_dec (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    // A dark digit keeps its anode low so the slot timing stays uniform.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= cur_dark ? SEG_OFF : cur_glyph;
            dp  <= cur_dark | ~dp_q[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a 4-cycle scan period.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_tick;

    int checks   = 0;
    int failures = 0;

    seg7_scan_display #(
        .SCAN_DIV (4),
        .CNT_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .blank     (blank),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .scan_tick (scan_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        do begin
            edge1();
            n++;
        end while (an !== target && n < 40);
        chk("wait_an", {12'h0, an}, {12'h0, target});
    endtask

    task automatic slot(input string tag, input logic [3:0] target,
                        input logic [6:0] exp_seg, input logic exp_dp);
        wait_an(target);
        chk({tag, "_seg"}, {9'h0, seg}, {9'h0, exp_seg});
        chk({tag, "_dp"}, {15'h0, dp}, {15'h0, exp_dp});
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] p);
        wr_data = d;
        wr_dp   = p;
        wr_en   = 1'b1;
        edge1();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [3:0] an_exp [5];
        an_exp = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        wr_dp   = 4'b0000;
        blank   = 4'b0000;

        // Reset state
        repeat (3) edge1();
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_tick", {15'h0, scan_tick}, 16'h0000);
        rst = 1'b1;

        // Scan sequence: each anode held 4 cycles, tick while prescaler sits at 3
        for (int k = 1; k <= 17; k++) begin
            edge1();
            chk("scan_an", {12'h0, an}, {12'h0, an_exp[(k - 1) / 4]});
            chk("scan_tick", {15'h0, scan_tick}, {15'h0, (k % 4) == 3});
            chk("scan_seg", {9'h0, seg}, 16'h0040);
        end

        // 1234 with dp on digit 2
        write(16'h1234, 4'b0100);
        slot("d0_4", 4'hE, 7'b0011001, 1'b1);
        slot("d2_2", 4'hB, 7'b0100100, 1'b0);
        slot("d1_3", 4'hD, 7'b0110000, 1'b1);
        slot("d3_1", 4'h7, 7'b1111001, 1'b1);

        // Write into the active digit: seg updates on the second edge
        wait_an(4'hE);
        chk("lat_pre", {9'h0, seg}, 16'h0019);
        write(16'hABCD, 4'b0000);
        chk("lat_edge1", {9'h0, seg}, 16'h0019);
        edge1();
        chk("lat_edge2", {9'h0, seg}, 16'h0021);

        // Live blank on digit 1
        blank = 4'b0010;
        slot("blank_d1", 4'hD, 7'h7F, 1'b1);
        slot("d2_b", 4'hB, 7'b0000011, 1'b1);
        slot("d3_A", 4'h7, 7'b0001000, 1'b1);

        // Write on the same edge as the digit 0 -> 1 wrap
        wait_an(4'hE);
        edge1();
        edge1();
        chk("wrap_tick", {15'h0, scan_tick}, 16'h0001);
        blank   = 4'b0000;
        wr_data = 16'h0090;
        wr_dp   = 4'b0000;
        wr_en   = 1'b1;
        edge1();
        wr_en   = 1'b0;
        chk("wrap_an_hold", {12'h0, an}, 16'h000E);
        edge1();
        chk("wrap_an", {12'h0, an}, 16'h000D);
        chk("wrap_seg9", {9'h0, seg}, 16'h0010);

        // Asynchronous reset mid-slot
        #2;
        rst = 1'b0;
        #1;
        chk("async_an", {12'h0, an}, 16'h000F);
        chk("async_seg", {9'h0, seg}, 16'h007F);
        chk("async_dp", {15'h0, dp}, 16'h0001);
        chk("async_tick", {15'h0, scan_tick}, 16'h0000);
        edge1();
        edge1();
        rst = 1'b1;

        // Restart from digit 0 with a full period and cleared data
        for (int k = 1; k <= 5; k++) begin
            edge1();
            chk("restart_an", {12'h0, an}, {12'h0, an_exp[(k - 1) / 4]});
            chk("restart_tick", {15'h0, scan_tick}, {15'h0, (k % 4) == 3});
        end
        chk("restart_seg", {9'h0, seg}, 16'h0040);

        // Leading-zero behaviour
        write(16'h0007, 4'b0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        slot("lz7_d3", 4'h7, 7'h7F, 1'b1);
        slot("lz7_d2", 4'hB, 7'h7F, 1'b1);
        slot("lz7_d1", 4'hD, 7'h7F, 1'b1);
`else
        slot("lz7_d3", 4'h7, 7'b1000000, 1'b1);
        slot("lz7_d2", 4'hB, 7'b1000000, 1'b1);
        slot("lz7_d1", 4'hD, 7'b1000000, 1'b1);
`endif
        slot("lz7_d0", 4'hE, 7'b1111000, 1'b1);

        write(16'h0000, 4'b0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        slot("lz0_d3", 4'h7, 7'h7F, 1'b1);
        slot("lz0_d2", 4'hB, 7'h7F, 1'b1);
        slot("lz0_d1", 4'hD, 7'h7F, 1'b1);
`else
        slot("lz0_d3", 4'h7, 7'b1000000, 1'b1);
        slot("lz0_d2", 4'hB, 7'b1000000, 1'b1);
        slot("lz0_d1", 4'hD, 7'b1000000, 1'b1);
`endif
        slot("lz0_d0", 4'hE, 7'b1000000, 1'b1);

        write(16'h0100, 4'b1000);
        slot("lzdp_d3", 4'h7, 7'b1000000, 1'b0);
        slot("lzdp_d2", 4'hB, 7'b1111001, 1'b1);
        slot("lzdp_d1", 4'hD, 7'b1000000, 1'b1);
        slot("lzdp_d0", 4'hE, 7'b1000000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
